bkm_shift_add_iter: RTL

- Sequential shift-and-add iteration engine for the BKM datapath. Sits directly upstream of add_subb, which it instantiates internally.
- Each cycle it drives one add_subb with a = x_n and b = x_n >>> n. It sets subb_b from the current digit and registers the sum back into x.
- Computes x_{n+1} = x_n + d_n*(x_n >>> n) for n = 0..N_ITER-1, with d_n in {-1,0,+1}. The digit is supplied per iteration by the upstream digit-selection logic.

---
 rtl/bkm_shift_add_iter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/bkm_shift_add_iter.sv
// BKM shift-and-add iteration engine: x <= x + d_n * (x >>> n) for n = 0..N_ITER-1.
// Optional macro BKM_SHIFT_ADD_SAT_EN saturates x on signed overflow instead of wrapping.

module add_subb #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         subb_a,
  input  logic         subb_b,
  output logic [W-1:0] sum
);

  logic [W-1:0] op_a;
  logic [W-1:0] op_b;

  assign op_a = subb_a ? (~a + W'(1)) : a;
  assign op_b = subb_b ? (~b + W'(1)) : b;
  assign sum  = op_a + op_b;

endmodule

module bkm_shift_add_iter #(
  parameter int unsigned W      = 8,
  parameter int unsigned N_ITER = 8,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                start,
  input  logic signed [W-1:0] x0,
  input  logic [1:0]          d_in,
  output logic [CNT_W-1:0]    iter,
  output logic                busy,
  output logic                done,
  output logic signed [W-1:0] x_out,
  output logic                ovf,
  output logic                derr
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_ITER - 1);

  state_t              state_q, state_d;
  logic signed [W-1:0] x_q, x_d;
  logic [CNT_W-1:0]    iter_q, iter_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic                derr_q, derr_d;

  logic signed [W-1:0] sh;
  logic [W-1:0]        sum;
  logic signed [W-1:0] x_step;
  logic                d_add, d_sub, d_ill;
  logic                same_sign;
  logic                ovf_c;

  assign d_add = (d_in == 2'b01);
  assign d_sub = (d_in == 2'b11);
  assign d_ill = (d_in == 2'b10);

  // Arithmetic shift keeps the sign, so large shifts of a negative x yield -1.
  assign sh = x_q >>> iter_q;

  add_subb #(.W(W)) u_add_subb (
    .a      (x_q),
    .b      (sh),
    .subb_a (1'b0),
    .subb_b (d_sub),
    .sum    (sum)
  );

  // Effective operand signs match for add when signs agree, for subtract when they differ.
  assign same_sign = (x_q[W-1] == sh[W-1]);
  assign ovf_c     = (d_add | d_sub) & (d_sub ? ~same_sign : same_sign) & (sum[W-1] != x_q[W-1]);

`ifdef BKM_SHIFT_ADD_SAT_EN
  localparam logic signed [W-1:0] X_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] X_MIN = {1'b1, {(W-1){1'b0}}};

  always_comb begin
    x_step = x_q;
    if (ovf_c)              x_step = x_q[W-1] ? X_MIN : X_MAX;
    else if (d_add | d_sub) x_step = $signed(sum);
  end
`else
  assign x_step = (d_add | d_sub) ? $signed(sum) : x_q;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    iter_d  = iter_q;
    ovf_d   = ovf_q;
    derr_d  = derr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          x_d     = x0;
          iter_d  = '0;
          ovf_d   = 1'b0;
          derr_d  = 1'b0;
        end
      end
      RUN: begin
        x_d    = x_step;
        ovf_d  = ovf_q | ovf_c;
        derr_d = derr_q | d_ill;
        if (iter_q == LAST_ITER) state_d = DONE;
        else                     iter_d  = iter_q + CNT_W'(1);
      end
      DONE: begin
        state_d = IDLE;
        iter_d  = '0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      derr_q  <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      x_q     <= x_d;
      iter_q  <= iter_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      derr_q  <= derr_d;
    end
  end

  assign iter  = iter_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign x_out = x_q;
  assign ovf   = ovf_q;
  assign derr  = derr_q;

endmodule
